// File: rtl/asi_regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : asi_regbank_pkg
// Description : Shared constants, register map, CTRL layout and byte-merge
//               helper for the asi user-side register bank.
// Contents    : AXI_DW/AXI_AW/AXI_WSTRBW bus widths, REG_* byte addresses,
//               CTRL_* / STATUS_* bit positions, IRQMASK, TYPE_CTRL,
//               merge_bytes().
// Revision    : 1.0 - initial release
// ============================================================================
package asi_regbank_pkg;

  localparam int AXI_DW     = 32;
  localparam int AXI_AW     = 16;
  localparam int AXI_WSTRBW = AXI_DW / 8;

  // Byte addresses within the 64-byte window (the map aliases above bit 5).
  localparam logic [5:0] REG_ID       = 6'h00;
  localparam logic [5:0] REG_CTRL     = 6'h04;
  localparam logic [5:0] REG_STATUS   = 6'h08;
  localparam logic [5:0] REG_COUNT    = 6'h0C;
  localparam logic [5:0] REG_SCRATCH0 = 6'h10;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_CNT_CLR = 2;

  localparam int STATUS_EVT_SEEN = 0;
  localparam int STATUS_CNT_OVF  = 1;

  localparam logic [1:0] IRQMASK = 2'b11;

  typedef struct packed {
    logic [28:0] scratch;
    logic        cnt_clr;
    logic        irq_en;
    logic        enable;
  } TYPE_CTRL;

  // Replace only the byte lanes whose strobe is set.
  function automatic logic [AXI_DW-1:0] merge_bytes(
    input logic [AXI_DW-1:0]     old_v,
    input logic [AXI_DW-1:0]     new_v,
    input logic [AXI_WSTRBW-1:0] strb
  );
    logic [AXI_DW-1:0] r;
    r = old_v;
    for (int k = 0; k < AXI_WSTRBW; k++) begin
      if (strb[k]) r[8*k +: 8] = new_v[8*k +: 8];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/asi_regbank_if.sv
`default_nettype none
// ============================================================================
// Module      : asi_regbank_if
// Description : User-side word port of the asi slave: write strobe, address,
//               data and byte enables toward the register bank, read data
//               back.
// Ports       : m_we, m_addr, m_wdata, m_wstrb (master -> slave)
//               m_rdata                        (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface asi_regbank_if;
  import asi_regbank_pkg::*;

  logic                  m_we;
  logic [AXI_AW-1:0]     m_addr;
  logic [AXI_DW-1:0]     m_wdata;
  logic [AXI_WSTRBW-1:0] m_wstrb;
  logic [AXI_DW-1:0]     m_rdata;

  modport master (
    output m_we, m_addr, m_wdata, m_wstrb,
    input  m_rdata
  );

  modport slave (
    input  m_we, m_addr, m_wdata, m_wstrb,
    output m_rdata
  );
endinterface
`default_nettype wire

// File: rtl/asi_regbank_rdpipe.sv
`default_nettype none
// ============================================================================
// Module      : asi_regbank_rdpipe
// Description : DEPTH-stage delay line with asynchronous active-low reset.
//               DEPTH=0 is a straight wire. Used to align read data (and can
//               align a matching valid bit) with the read wait-state count.
// Ports       : clk, reset_n, din[WIDTH], dout[WIDTH]
// Revision    : 1.0 - initial release
// ============================================================================
module asi_regbank_rdpipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic [WIDTH-1:0] din,
  output logic      [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_comb
    logic unused_ctl;
    assign unused_ctl = clk ^ reset_n;
    assign dout       = din;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        stage <= '0;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule
`default_nettype wire

// File: rtl/asi_regbank.sv
`default_nettype none
// ============================================================================
// Module      : asi_regbank
// Description : Control/status register bank on the usr_clk side of the asi
//               slave. ID, CTRL, W1C STATUS, event COUNT and NSCRATCH scratch
//               words; read data returned SLV_WS cycles after the address.
// Ports       : usr_clk, usr_reset_n (async, active-low)
//               bus     - asi_regbank_if.slave (m_we/m_addr/m_wdata/m_wstrb in,
//                         m_rdata out)
//               evt_i   - single-cycle event pulse
//               ctrl_o  - current CTRL register
//               irq_o   - level interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module asi_regbank import asi_regbank_pkg::*; #(
  parameter int          SLV_WS   = 2,
  parameter int          NSCRATCH = 4,
  parameter logic [31:0] ID_VALUE = 32'h0A51_0001
) (
  input  wire logic        usr_clk,
  input  wire logic        usr_reset_n,
  asi_regbank_if.slave     bus,
  input  wire logic        evt_i,
  output logic [31:0]      ctrl_o,
  output logic             irq_o
);

  if (AXI_DW != 32) begin : g_dw_check
    $error("asi_regbank requires AXI_DW == 32");
  end
  if (NSCRATCH < 1 || NSCRATCH > 12) begin : g_nscratch_check
    $error("asi_regbank NSCRATCH must be in 1..12");
  end

  localparam logic [3:0] IDX_ID     = REG_ID[5:2];
  localparam logic [3:0] IDX_CTRL   = REG_CTRL[5:2];
  localparam logic [3:0] IDX_STATUS = REG_STATUS[5:2];
  localparam logic [3:0] IDX_COUNT  = REG_COUNT[5:2];
  localparam int         IDX_SCR0   = int'(REG_SCRATCH0[5:2]);

  logic [3:0] widx;
  logic       unused_addr_bits;

  assign widx             = bus.m_addr[5:2];
  assign unused_addr_bits = ^{bus.m_addr[AXI_AW-1:6], bus.m_addr[1:0]};

  TYPE_CTRL          ctrl;
  TYPE_CTRL          ctrl_wr;
  logic [1:0]        status;
  logic [1:0]        status_clr;
  logic [1:0]        status_set;
  logic [31:0]       count;
  logic [31:0]       scratch [NSCRATCH];
  logic              wr_ctrl;
  logic              wr_status;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              cnt_wrap;
  logic [AXI_DW-1:0] rd_mux;

  assign wr_ctrl   = bus.m_we && (widx == IDX_CTRL);
  assign wr_status = bus.m_we && (widx == IDX_STATUS);

  // cnt_clr is a write-only pulse: it is never stored, so CTRL reads it as 0.
  always_comb begin
    ctrl_wr         = TYPE_CTRL'(merge_bytes(ctrl, bus.m_wdata, bus.m_wstrb));
    ctrl_wr.cnt_clr = 1'b0;
  end

  assign cnt_clr  = wr_ctrl && bus.m_wstrb[0] && bus.m_wdata[CTRL_CNT_CLR];
  // Increment sees the registered enable, so a same-cycle CTRL write does not
  // affect it. A clear suppresses the increment and therefore any wrap.
  assign cnt_inc  = ctrl.enable && evt_i;
  assign cnt_wrap = cnt_inc && !cnt_clr && (count == 32'hFFFF_FFFF);

  always_comb begin
    status_clr = 2'b00;
    if (wr_status && bus.m_wstrb[0]) status_clr = bus.m_wdata[1:0];
    status_set                  = 2'b00;
    status_set[STATUS_EVT_SEEN] = evt_i;
    status_set[STATUS_CNT_OVF]  = cnt_wrap;
  end

  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      ctrl   <= '0;
      status <= '0;
      count  <= '0;
    end else begin
      if (wr_ctrl) ctrl <= ctrl_wr;
      // Hardware set applied after the clear so a coincident set wins.
      status <= (status & ~status_clr) | status_set;
      if (cnt_clr) begin
        count <= '0;
      end else if (cnt_inc) begin
        count <= count + 32'd1;
      end
    end
  end

  for (genvar i = 0; i < NSCRATCH; i++) begin : g_scratch
    logic [31:0] word;

    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
      if (!usr_reset_n) begin
        word <= '0;
      end else if (bus.m_we && (widx == 4'(IDX_SCR0 + i))) begin
        word <= merge_bytes(word, bus.m_wdata, bus.m_wstrb);
      end
    end

    assign scratch[i] = word;
  end

  // Read mux is evaluated on every non-write cycle; write cycles yield 0.
  always_comb begin
    rd_mux = '0;
    if (!bus.m_we) begin
      case (widx)
        IDX_ID:     rd_mux = ID_VALUE;
        IDX_CTRL:   rd_mux = ctrl;
        IDX_STATUS: rd_mux = {30'd0, status};
        IDX_COUNT:  rd_mux = count;
        default: begin
          for (int i = 0; i < NSCRATCH; i++) begin
            if (widx == 4'(IDX_SCR0 + i)) rd_mux = scratch[i];
          end
        end
      endcase
    end
  end

  asi_regbank_rdpipe #(
    .DEPTH (SLV_WS),
    .WIDTH (AXI_DW)
  ) u_rdpipe (
    .clk     (usr_clk),
    .reset_n (usr_reset_n),
    .din     (rd_mux),
    .dout    (bus.m_rdata)
  );

  assign ctrl_o = ctrl;
  assign irq_o  = (|(status & IRQMASK)) & ctrl.irq_en;

endmodule
`default_nettype wire
